// File: rtl/shift_register_driver_pkg.sv
// Shared definitions for shift-register controllers: state encoding and pin bundle.
// Reused by future SIPO drivers and by the bench model.
package shift_register_driver_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_BIT_LO   = 3'd1;
    localparam logic [STATE_W-1:0] ST_BIT_HI   = 3'd2;
    localparam logic [STATE_W-1:0] ST_LATCH_HI = 3'd3;
    localparam logic [STATE_W-1:0] ST_LATCH_LO = 3'd4;
    localparam logic [STATE_W-1:0] ST_CLR      = 3'd5;

    typedef struct packed {
        logic ds;
        logic shcp;
        logic stcp;
        logic mr_bar;
    } sr_pins_t;

    localparam sr_pins_t PINS_RESET = '{ds: 1'b0, shcp: 1'b0, stcp: 1'b0, mr_bar: 1'b1};

endpackage

// File: rtl/shift_register_driver_if.sv
// Host-side handshake bundle of the shift-register driver.
// master = system logic issuing words/clears, slave = the driver.
interface shift_register_driver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             clear_in;
    logic             oe_in;
    logic             done_out;

    modport master (
        output data_in, valid_in, clear_in, oe_in,
        input  ready_out, done_out
    );

    modport slave (
        input  data_in, valid_in, clear_in, oe_in,
        output ready_out, done_out
    );
endinterface

// File: rtl/shift_register_driver_phase_timer.sv
// DIV-cycle down-counter: tick is high in the last cycle of every DIV-cycle phase.
// load restarts the phase; the counter reloads itself after terminal count.
module sr_phase_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CNT_TOP;
        end else if (load || count == '0) begin
            count <= CNT_TOP;
        end else begin
            count <= count - CNT_W'(1);
        end
    end

    assign tick = (count == '0);
endmodule

// File: rtl/shift_register_driver.sv
// Serial driver for cascadable 8-bit SIPO shift/storage registers: shifts a word out
// LSB first on ds/shcp, then pulses stcp; also runs a master-reset clear sequence.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting; clear_in wins over valid_in
// BIT_LO   | shcp low, ds shows current bit (setup phase)
// BIT_HI   | shcp high, ds held (register samples on the rise)
// LATCH_HI | stcp high, storage stage copies the shift stage
// LATCH_LO | stcp low, then done_out and back to IDLE
// CLR      | mr_bar low, shift stage cleared before latching zeros
module shift_register_driver
    import shift_register_driver_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    shift_register_driver_if.slave        bus,
    output logic                          ds,
    output logic                          shcp,
    output logic                          stcp,
    output logic                          mr_bar,
    output logic                          oe_bar
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [STATE_W-1:0] state, state_nxt;
    logic [WIDTH-1:0]   buffer, buffer_nxt;
    logic [IDX_W-1:0]   bit_idx;
    sr_pins_t           pins_q, pins_nxt;
    logic               tick;
    logic               load;
    logic               enter_bit;
    logic               done_q;

    sr_phase_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.clear_in) begin
                    state_nxt = ST_CLR;
                end else if (bus.valid_in) begin
                    state_nxt = ST_BIT_LO;
                end
            end
            ST_BIT_LO:   if (tick) state_nxt = ST_BIT_HI;
            ST_BIT_HI: begin
                if (tick) begin
                    state_nxt = (bit_idx == IDX_W'(WIDTH - 1)) ? ST_LATCH_HI : ST_BIT_LO;
                end
            end
            ST_LATCH_HI: if (tick) state_nxt = ST_LATCH_LO;
            ST_LATCH_LO: if (tick) state_nxt = ST_IDLE;
            ST_CLR:      if (tick) state_nxt = ST_LATCH_HI;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign load      = (state_nxt != state);
    assign enter_bit = (state_nxt == ST_BIT_LO) && (state != ST_BIT_LO);

    // Buffer shifts right after each bit, so the bit on ds is always buffer[0].
    always_comb begin
        buffer_nxt = buffer;
        if (state == ST_IDLE && state_nxt == ST_BIT_LO) begin
            buffer_nxt = bus.data_in;
        end else if (state == ST_BIT_HI && state_nxt == ST_BIT_LO) begin
            buffer_nxt = buffer >> 1;
        end
    end

    // Pins are registered from the next state so they change on the same edge as the FSM.
    always_comb begin
        pins_nxt        = pins_q;
        pins_nxt.shcp   = (state_nxt == ST_BIT_HI);
        pins_nxt.stcp   = (state_nxt == ST_LATCH_HI);
        pins_nxt.mr_bar = (state_nxt != ST_CLR);
        if (enter_bit) begin
            pins_nxt.ds = buffer_nxt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            buffer  <= '0;
            bit_idx <= '0;
            pins_q  <= PINS_RESET;
            done_q  <= 1'b0;
            oe_bar  <= 1'b1;
        end else begin
            state   <= state_nxt;
            buffer  <= buffer_nxt;
            pins_q  <= pins_nxt;
            done_q  <= (state == ST_LATCH_LO) && (state_nxt == ST_IDLE);
            oe_bar  <= ~bus.oe_in;
            if (state == ST_IDLE) begin
                bit_idx <= '0;
            end else if (state == ST_BIT_HI && state_nxt == ST_BIT_LO) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

    assign ds     = pins_q.ds;
    assign shcp   = pins_q.shcp;
    assign stcp   = pins_q.stcp;
    assign mr_bar = pins_q.mr_bar;

    assign bus.ready_out = (state == ST_IDLE) && !bus.clear_in;
    assign bus.done_out  = done_q;
endmodule

// File: tb/tb_shift_register_driver.sv
// Bench for shift_register_driver: pin-level SIPO register models behind two DUTs
// (8-bit/DIV=2 and 16-bit/DIV=1) with a scoreboard of expected latch values and latencies.
module tb_shift_register_driver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    shift_register_driver_if #(.WIDTH(8))  bus8 ();
    shift_register_driver_if #(.WIDTH(16)) bus16 ();
    logic ds8, shcp8, stcp8, mr8, oe_bar8;
    logic ds16, shcp16, stcp16, mr16, oe_bar16;

    shift_register_driver #(.WIDTH(8), .DIV(2)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8),
        .ds(ds8), .shcp(shcp8), .stcp(stcp8), .mr_bar(mr8), .oe_bar(oe_bar8)
    );
    shift_register_driver #(.WIDTH(16), .DIV(1)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16),
        .ds(ds16), .shcp(shcp16), .stcp(stcp16), .mr_bar(mr16), .oe_bar(oe_bar16)
    );

    typedef struct { logic [15:0] data; int latency; } sb_t;
    sb_t sb8[$], sb16[$];
    int n_cmp = 0, n_bad = 0;

    // SIPO models: ds enters the MSB end so the first bit shifted ends up at out[0].
    logic [7:0]  m8_sr = '0, m8_lat = '0;
    logic        m8_pshcp = 1'b0, m8_pstcp = 1'b0;
    int          m8_rises = 0, m8_stcp = 0, m8_mr_low = 0, now8;
    logic        m8_ds[$];
    int          m8_hs[$], m8_done[$];
    logic [15:0] m16_sr = '0, m16_lat = '0;
    logic        m16_pshcp = 1'b0, m16_pstcp = 1'b0;
    int          m16_rises = 0, now16;
    int          m16_rt[$], m16_hs[$], m16_done[$];

    wire [7:0] out8 = m8_lat & {8{~oe_bar8}};
    wire [6:0] pins8  = {ds8, shcp8, stcp8, mr8, oe_bar8, bus8.done_out, bus8.ready_out};
    wire [6:0] pins16 = {ds16, shcp16, stcp16, mr16, oe_bar16, bus16.done_out, bus16.ready_out};

    // now = the clock edge that will sample the values seen at this falling edge
    always @(negedge clk) begin
        now8 = cyc + 1;
        if (!mr8) begin m8_sr = '0; m8_mr_low++; end
        if (shcp8 && !m8_pshcp) begin m8_sr = {ds8, m8_sr[7:1]}; m8_rises++; m8_ds.push_back(ds8); end
        if (stcp8 && !m8_pstcp) begin m8_lat = m8_sr; m8_stcp++; end
        if (!reset && bus8.valid_in && bus8.ready_out) m8_hs.push_back(now8);
        if (bus8.done_out) m8_done.push_back(now8);
        m8_pshcp = shcp8;
        m8_pstcp = stcp8;
    end

    always @(negedge clk) begin
        now16 = cyc + 1;
        if (!mr16) m16_sr = '0;
        if (shcp16 && !m16_pshcp) begin m16_sr = {ds16, m16_sr[15:1]}; m16_rises++; m16_rt.push_back(now16); end
        if (stcp16 && !m16_pstcp) m16_lat = m16_sr;
        if (!reset && bus16.valid_in && bus16.ready_out) m16_hs.push_back(now16);
        if (bus16.done_out) m16_done.push_back(now16);
        m16_pshcp = shcp16;
        m16_pstcp = stcp16;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send8(input logic [7:0] d);
        bus8.data_in  = d;
        bus8.valid_in = 1'b1;
        step();
        bus8.valid_in = 1'b0;
    endtask

    task automatic wait_done(input bit wide, input int n, output bit ok);
        int i;
        i = 0;
        while (((wide ? m16_done.size() : m8_done.size()) < n) && i < 200) begin
            step();
            i++;
        end
        ok = ((wide ? m16_done.size() : m8_done.size()) >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (pins8 !== 7'b0001101) begin n_bad++; $display("FAIL reset_pins8: got %b want %b", pins8, 7'b0001101); end
        n_cmp++; if (pins16 !== 7'b0001101) begin n_bad++; $display("FAIL reset_pins16: got %b want %b", pins16, 7'b0001101); end
        bus8.clear_in = 1'b1;
        #1;
        n_cmp++; if (bus8.ready_out !== 1'b0) begin n_bad++; $display("FAIL ready_with_clear: got %b want 0", bus8.ready_out); end
        bus8.clear_in = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_transfer();
        int r0, p0, l0, t_hs, t_done;
        logic [7:0] seq;
        sb_t e;
        bit ok;
        bus8.oe_in = 1'b1;
        step();
        r0 = m8_rises; p0 = m8_stcp; l0 = m8_ds.size();
        sb8.push_back('{data: 16'h00A5, latency: 37});
        send8(8'hA5);
        wait_done(1'b0, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL xfer_done_timeout: got 0 done pulses want 1"); return; end
        e = sb8.pop_front(); t_hs = m8_hs.pop_front(); t_done = m8_done.pop_front();
        n_cmp++; if (t_done - t_hs !== e.latency) begin n_bad++; $display("FAIL xfer_latency: got %0d want %0d", t_done - t_hs, e.latency); end
        n_cmp++; if (m8_rises - r0 !== 8) begin n_bad++; $display("FAIL xfer_shcp_rises: got %0d want 8", m8_rises - r0); end
        n_cmp++; if (m8_stcp - p0 !== 1) begin n_bad++; $display("FAIL xfer_stcp_pulses: got %0d want 1", m8_stcp - p0); end
        if (m8_ds.size() >= l0 + 8) begin
            for (int i = 0; i < 8; i++) seq[i] = m8_ds[l0 + i];
            n_cmp++; if (seq !== 8'hA5) begin n_bad++; $display("FAIL xfer_ds_bits_lsb_first: got %h want a5", seq); end
        end
        n_cmp++; if (m8_lat !== e.data[7:0]) begin n_bad++; $display("FAIL xfer_latch: got %h want %h", m8_lat, e.data[7:0]); end
        n_cmp++; if (out8 !== 8'hA5) begin n_bad++; $display("FAIL xfer_out: got %h want a5", out8); end
    endtask

    task automatic test_oe();
        int r0, p0, t_hs, t_done;
        sb_t e;
        bit ok;
        bus8.oe_in = 1'b0;
        step();
        sb8.push_back('{data: 16'h00A5, latency: 37});
        send8(8'hA5);
        wait_done(1'b0, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL oe_done_timeout: got 0 done pulses want 1"); return; end
        e = sb8.pop_front(); t_hs = m8_hs.pop_front(); t_done = m8_done.pop_front();
        n_cmp++; if (t_done - t_hs !== e.latency) begin n_bad++; $display("FAIL oe_latency: got %0d want %0d", t_done - t_hs, e.latency); end
        n_cmp++; if (m8_lat !== e.data[7:0]) begin n_bad++; $display("FAIL oe_latch: got %h want %h", m8_lat, e.data[7:0]); end
        n_cmp++; if (out8 !== 8'h00) begin n_bad++; $display("FAIL oe_off_out: got %h want 00", out8); end
        n_cmp++; if (oe_bar8 !== 1'b1) begin n_bad++; $display("FAIL oe_off_pin: got %b want 1", oe_bar8); end
        r0 = m8_rises; p0 = m8_stcp;
        bus8.oe_in = 1'b1;
        step();
        step();
        n_cmp++; if (out8 !== 8'hA5) begin n_bad++; $display("FAIL oe_on_out: got %h want a5", out8); end
        n_cmp++; if ((m8_rises - r0) + (m8_stcp - p0) !== 0) begin n_bad++; $display("FAIL oe_on_no_activity: got %0d edges want 0", (m8_rises - r0) + (m8_stcp - p0)); end
    endtask

    task automatic test_back_to_back();
        int h0, r0, i, hs1, hs2, d1, d2;
        sb_t e1, e2;
        bit ok;
        h0 = m8_hs.size(); r0 = m8_rises;
        sb8.push_back('{data: 16'h00A5, latency: 37});
        sb8.push_back('{data: 16'h003C, latency: 37});
        bus8.data_in  = 8'hA5;
        bus8.valid_in = 1'b1;
        i = 0;
        while (m8_hs.size() < h0 + 1 && i < 50) begin step(); i++; end
        bus8.data_in = 8'h3C;
        i = 0;
        while (m8_hs.size() < h0 + 2 && i < 100) begin step(); i++; end
        bus8.valid_in = 1'b0;
        wait_done(1'b0, 2, ok);
        n_cmp++; if (!ok || m8_hs.size() < 2) begin n_bad++; $display("FAIL b2b_timeout: got %0d done pulses want 2", m8_done.size()); return; end
        hs1 = m8_hs.pop_front(); hs2 = m8_hs.pop_front();
        d1 = m8_done.pop_front(); d2 = m8_done.pop_front();
        e1 = sb8.pop_front(); e2 = sb8.pop_front();
        n_cmp++; if (hs2 !== d1) begin n_bad++; $display("FAIL b2b_accept_at_done: got edge %0d want %0d", hs2, d1); end
        n_cmp++; if (d1 - hs1 !== e1.latency) begin n_bad++; $display("FAIL b2b_latency1: got %0d want %0d", d1 - hs1, e1.latency); end
        n_cmp++; if (d2 - hs2 !== e2.latency) begin n_bad++; $display("FAIL b2b_latency2: got %0d want %0d", d2 - hs2, e2.latency); end
        n_cmp++; if (m8_rises - r0 !== 16) begin n_bad++; $display("FAIL b2b_shcp_rises: got %0d want 16", m8_rises - r0); end
        n_cmp++; if (out8 !== e2.data[7:0]) begin n_bad++; $display("FAIL b2b_out: got %h want %h", out8, e2.data[7:0]); end
    endtask

    task automatic test_clear();
        int h0, p0, mr0, r0, t_clr, t_done, t_hs;
        sb_t e;
        bit ok;
        sb8.push_back('{data: 16'h00FF, latency: 37});
        send8(8'hFF);
        wait_done(1'b0, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL clr_preload_timeout: got 0 done pulses want 1"); return; end
        e = sb8.pop_front(); t_hs = m8_hs.pop_front(); t_done = m8_done.pop_front();
        n_cmp++; if (out8 !== e.data[7:0]) begin n_bad++; $display("FAIL clr_preload_out: got %h want %h", out8, e.data[7:0]); end
        h0 = m8_hs.size(); p0 = m8_stcp; mr0 = m8_mr_low; r0 = m8_rises;
        sb8.push_back('{data: 16'h0000, latency: 7});
        bus8.clear_in = 1'b1;
        bus8.valid_in = 1'b1;
        bus8.data_in  = 8'h55;
        t_clr = cyc + 1;
        #1;
        n_cmp++; if (bus8.ready_out !== 1'b0) begin n_bad++; $display("FAIL clr_ready: got %b want 0", bus8.ready_out); end
        step();
        bus8.clear_in = 1'b0;
        bus8.valid_in = 1'b0;
        wait_done(1'b0, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL clr_done_timeout: got 0 done pulses want 1"); return; end
        e = sb8.pop_front(); t_done = m8_done.pop_front();
        n_cmp++; if (t_done - t_clr !== e.latency) begin n_bad++; $display("FAIL clr_latency: got %0d want %0d", t_done - t_clr, e.latency); end
        n_cmp++; if (m8_hs.size() !== h0) begin n_bad++; $display("FAIL clr_valid_blocked: got %0d accepts want 0", m8_hs.size() - h0); end
        n_cmp++; if (m8_mr_low - mr0 !== 2) begin n_bad++; $display("FAIL clr_mr_low_cycles: got %0d want 2", m8_mr_low - mr0); end
        n_cmp++; if (m8_stcp - p0 !== 1) begin n_bad++; $display("FAIL clr_stcp_pulses: got %0d want 1", m8_stcp - p0); end
        n_cmp++; if (m8_rises !== r0) begin n_bad++; $display("FAIL clr_no_shcp: got %0d rises want 0", m8_rises - r0); end
        n_cmp++; if (out8 !== e.data[7:0]) begin n_bad++; $display("FAIL clr_out: got %h want %h", out8, e.data[7:0]); end
    endtask

    task automatic test_reset_mid();
        int r0, p0, i, t_hs, t_done;
        sb_t e;
        bit ok;
        sb8.push_back('{data: 16'h0081, latency: 37});
        send8(8'h81);
        wait_done(1'b0, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_preload_timeout: got 0 done pulses want 1"); return; end
        e = sb8.pop_front(); t_hs = m8_hs.pop_front(); t_done = m8_done.pop_front();
        n_cmp++; if (m8_lat !== e.data[7:0]) begin n_bad++; $display("FAIL rstmid_preload_latch: got %h want %h", m8_lat, e.data[7:0]); end
        r0 = m8_rises; p0 = m8_stcp;
        send8(8'h0F);
        i = 0;
        while (m8_rises - r0 < 3 && i < 60) begin step(); i++; end
        n_cmp++; if (m8_rises - r0 !== 3) begin n_bad++; $display("FAIL rstmid_third_rise: got %0d rises want 3", m8_rises - r0); end
        reset = 1'b1;
        step();
        n_cmp++; if (pins8 !== 7'b0001101) begin n_bad++; $display("FAIL rstmid_pins: got %b want %b", pins8, 7'b0001101); end
        n_cmp++; if (m8_lat !== 8'h81) begin n_bad++; $display("FAIL rstmid_latch_kept: got %h want 81", m8_lat); end
        reset = 1'b0;
        m8_hs.delete();
        step();
        step();
        n_cmp++; if (out8 !== 8'h81) begin n_bad++; $display("FAIL rstmid_out: got %h want 81", out8); end
        repeat (40) step();
        n_cmp++; if (m8_done.size() + (m8_stcp - p0) !== 0) begin n_bad++; $display("FAIL rstmid_no_completion: got %0d done/stcp events want 0", m8_done.size() + (m8_stcp - p0)); end
    endtask

    task automatic test_wide();
        int r0, b, t_hs, t_done;
        sb_t e;
        bit ok;
        bus16.oe_in = 1'b1;
        step();
        r0 = m16_rises; b = m16_rt.size();
        sb16.push_back('{data: 16'hBEEF, latency: 35});
        bus16.data_in  = 16'hBEEF;
        bus16.valid_in = 1'b1;
        step();
        bus16.valid_in = 1'b0;
        wait_done(1'b1, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wide_done_timeout: got 0 done pulses want 1"); return; end
        e = sb16.pop_front(); t_hs = m16_hs.pop_front(); t_done = m16_done.pop_front();
        n_cmp++; if (t_done - t_hs !== e.latency) begin n_bad++; $display("FAIL wide_latency: got %0d want %0d", t_done - t_hs, e.latency); end
        n_cmp++; if (m16_rises - r0 !== 16) begin n_bad++; $display("FAIL wide_shcp_rises: got %0d want 16", m16_rises - r0); end
        for (int i = 1; i < 16; i++) begin
            if (b + i < m16_rt.size()) begin
                n_cmp++;
                if (m16_rt[b + i] - m16_rt[b + i - 1] !== 2) begin
                    n_bad++; $display("FAIL wide_rise_spacing_%0d: got %0d want 2", i, m16_rt[b + i] - m16_rt[b + i - 1]);
                end
            end
        end
        n_cmp++; if (m16_lat[7:0] !== e.data[7:0]) begin n_bad++; $display("FAIL wide_stage_lo: got %h want %h", m16_lat[7:0], e.data[7:0]); end
        n_cmp++; if (m16_lat[15:8] !== e.data[15:8]) begin n_bad++; $display("FAIL wide_stage_hi: got %h want %h", m16_lat[15:8], e.data[15:8]); end
    endtask

    initial begin
        reset          = 1'b1;
        bus8.data_in   = '0;
        bus8.valid_in  = 1'b0;
        bus8.clear_in  = 1'b0;
        bus8.oe_in     = 1'b0;
        bus16.data_in  = '0;
        bus16.valid_in = 1'b0;
        bus16.clear_in = 1'b0;
        bus16.oe_in    = 1'b0;
        test_reset();
        test_transfer();
        test_oe();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
